// File: rtl/div_unit_if.sv
// Purpose : handshake and data bundle between the execute stage and div_unit.
// Latency : none, this is a plain signal bundle.
// Backpressure: the master waits on o_busy; i_start is ignored while busy.
// Signals (DUT view):
//   i_start  request strobe, sampled only in IDLE or DONE
//   i_op     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a/i_b  dividend / divisor, sampled with i_start
//   o_busy   operation in flight
//   o_done   one-cycle pulse, o_result valid
//   o_result quotient or remainder, held until the next accepted start
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_start, i_op, i_a, i_b,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_op, i_a, i_b,
    output o_busy, o_done, o_result
  );
endinterface

// File: rtl/div_unit.sv
// Purpose : iterative RV32M DIV/DIVU/REM/REMU unit (restoring division, one step per clock).
// Latency : done 34 cycles after the start cycle (start edge, 32 CALC edges, 1 FIX edge);
//           with DIV_EARLY_OUT_EN, divide-by-zero and signed overflow finish in 2 cycles.
// Backpressure: no queueing; i_start is ignored while o_busy is high, the pipeline stalls on busy.
// Ports:
//   i_clk, i_rst   rising-edge clock, synchronous active-high reset
//   bus (slave)    i_start/i_op/i_a/i_b in, o_busy/o_done/o_result out (see div_unit_if)
// Optional build macro: DIV_EARLY_OUT_EN (special cases bypass CALC).
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel_rem;  // op[1]: return remainder instead of quotient
  logic             r_sa;
  logic             r_sb;
  logic             r_bz;       // divisor was zero
  logic             r_ovf;      // signed 0x80000000 / -1
  logic [XLEN-1:0]  r_q;        // holds |dividend|, shifts into the quotient
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_div;
  logic [XLEN-1:0]  r_a_orig;   // untouched dividend for the divide-by-zero remainder
  logic [XLEN-1:0]  r_result;

  logic             w_start_ok;
  logic             w_signed;
  logic             w_sa_in;
  logic             w_sb_in;
  logic             w_bz_in;
  logic             w_ovf_in;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic [XLEN-1:0]  w_rem_sh;
  logic [XLEN-1:0]  w_diff;
  logic             w_c;
  logic             w_last;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;

  assign w_start_ok = bus.i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_signed   = ~bus.i_op[0];
  assign w_sa_in    = w_signed & bus.i_a[XLEN-1];
  assign w_sb_in    = w_signed & bus.i_b[XLEN-1];
  // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_a    = w_sa_in ? -bus.i_a : bus.i_a;
  assign w_abs_b    = w_sb_in ? -bus.i_b : bus.i_b;
  assign w_bz_in    = (bus.i_b == '0);
  assign w_ovf_in   = w_signed && (bus.i_a == MIN_NEG) && (bus.i_b == '1);

  // One restoring step: shift in the next dividend bit, then trial-subtract
  // as rem' + ~div + 1. Carry out set means rem' >= div (same as ALU SLTU).
  // Before the last shift rem < 2^31, so dropping rem[XLEN-1] loses nothing.
  assign w_rem_sh       = {r_rem[XLEN-2:0], r_q[XLEN-1]};
  assign {w_c, w_diff}  = {1'b0, w_rem_sh} + {1'b0, ~r_div} + {{XLEN{1'b0}}, 1'b1};
  assign w_last         = (r_cnt == CNT_W'(XLEN - 1));

  // Sign fix-up plus the RISC-V special-case overrides.
  always_comb begin
    w_q_fix = (r_sa ^ r_sb) ? -r_q : r_q;
    w_r_fix = r_sa ? -r_rem : r_rem;
    if (r_bz) begin
      w_q_fix = '1;
      w_r_fix = r_a_orig;
    end else if (r_ovf) begin
      w_q_fix = MIN_NEG;
      w_r_fix = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.o_busy  = 1'b0;
    bus.o_done  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        bus.o_done = (r_state == S_DONE);
        if (bus.i_start) begin
`ifdef DIV_EARLY_OUT_EN
          w_state_nxt = (w_bz_in || w_ovf_in) ? S_FIX : S_CALC;
`else
          w_state_nxt = S_CALC;
`endif
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        bus.o_busy = 1'b1;
        if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        bus.o_busy  = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_sel_rem <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_bz      <= 1'b0;
      r_ovf     <= 1'b0;
      r_q       <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_a_orig  <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_sel_rem <= bus.i_op[1];
        r_sa      <= w_sa_in;
        r_sb      <= w_sb_in;
        r_bz      <= w_bz_in;
        r_ovf     <= w_ovf_in;
        r_q       <= w_abs_a;
        r_div     <= w_abs_b;
        r_rem     <= '0;
        r_a_orig  <= bus.i_a;
        r_cnt     <= '0;
      end else if (r_state == S_CALC) begin
        r_rem <= w_c ? w_diff : w_rem_sh;
        r_q   <= {r_q[XLEN-2:0], w_c};
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_FIX) begin
        r_result <= r_sel_rem ? w_r_fix : w_q_fix;
      end
    end
  end

  assign bus.o_result = r_result;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit that executes DIV, DIVU, REM and REMU beside the single-cycle ALU in the execute stage.
- Uses restoring division: one subtract-and-compare step per clock, on the same add/sub carry convention the ALU uses for SLTU.
- The pipeline stalls on `busy` and captures `result` on `done`.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only in IDLE or DONE
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- a  input  XLEN  dividend; sampled with start
- b  input  XLEN  divisor; sampled with start
- busy  output  1  high while an operation is in flight (CALC or FIX)
- done  output  1  one-cycle pulse when result becomes valid
- result  output  XLEN  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, result=0; counter and internal registers cleared. Reset takes priority over everything, including mid-operation. An in-flight operation is abandoned and produces no done.
- States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE with start=1 → CALC. On that edge the unit latches op and sign flags (signed ops only: sa=a[31], sb=b[31]), loads |a| and |b| (plain a and b for unsigned ops), clears the remainder register and sets count=0.
  - DONE with start=0 → IDLE; done drops after one cycle.
  - start while busy=1 is ignored; the bench checks that no state, result or latch changes.
- CALC step, one per edge:
  - rem' = {rem[XLEN-2:0], q[XLEN-1]}; q shifts left.
  - diff = rem' − divisor, computed as rem' + ~divisor + 1 with carry-out c.
  - If c=1: rem=diff, q[0]=1. Otherwise rem=rem', q[0]=0.
  - count increments. After the step with count=XLEN−1 → FIX.
- FIX, one edge:
  - Quotient is negated if sa≠sb (signed ops only).
  - Remainder is negated if sa=1 (signed ops only).
  - result takes the quotient or remainder selected by op[1]; done=1; state → DONE.
- Latency: done is high in the cycle after the 33rd edge following the start-sampling edge (32 CALC edges + 1 FIX edge). Accepted starts can therefore complete at most once every 34 cycles.
- Special cases, resolved in FIX by overriding the datapath:
  - b=0: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = a (original, unsigned-unmodified) for REM and REMU.
  - DIV overflow (a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- A start sampled in DONE (done=1 that cycle) is accepted. result keeps the old value until the new FIX edge.
- Arithmetic is modulo 2^XLEN. |0x80000000| is represented as unsigned 0x80000000.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: on an accepted start with b=0 or the DIV overflow pattern, the unit goes directly to FIX, bypassing CALC. done is high in the cycle after the 2nd edge, and busy is high for exactly 1 cycle. All other operations keep the full 34-cycle latency.
- When undefined: every operation takes the full 34-cycle latency. Special-case results come from the FIX override only. Result values are identical in both builds.

Test Plan:
- DIVU a=100, b=7 → result=14, done exactly 34 cycles after start edge; REMU same operands → result=2.
- DIV a=0xFFFFFFF9 (−7), b=2 → result=0xFFFFFFFD (−3); REM same operands → 0xFFFFFFFF (−1); DIV a=7, b=0xFFFFFFFE → 0xFFFFFFFD.
- DIVU a=5, b=0 → 0xFFFFFFFF; REM a=0xFFFFFFFB, b=0 → 0xFFFFFFFB. Latency is 34 cycles without DIV_EARLY_OUT_EN and 2 cycles with it.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Start DIVU 100/7, re-pulse start with a=1, b=1 at cycle 5 → ignored; result=14 at cycle 34. A start in the done cycle is accepted, and the old result holds until its FIX edge.
- Assert rst at cycle 10 of a DIV → next cycle busy=0, done=0, result=0. No done pulse follows, and a fresh start completes normally.
